idct_blok_hakemi: RTL and testbench

Block-granular round-robin arbiter that shares one inverse-cosine transformer between several dequantizer streams (Y/Cb/Cr). It sits between the per-component dequantizers and the transformer's `dq_*` input port. It grants one requester for one whole 8x8 block at a time. Each transformer output block is tagged with the id of the requester that supplied it, using a small in-order tag FIFO, and presented downstream with that id.

---
 rtl/idct_blok_hakemi_pkg.sv | 12 +
 rtl/idct_blok_hakemi_etiket_fifo.sv | 61 ++++++
 rtl/idct_blok_hakemi.sv | 152 +++++++++++++++
 tb/tb_idct_blok_hakemi.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_blok_hakemi_pkg.sv
// Shared widths and constants for the IDCT block arbiter slice.
package idct_blok_hakemi_pkg;

    localparam int unsigned Q_BIT                     = 12;
    localparam int unsigned BLOCK_BIT                 = 3;
    localparam int unsigned PIXEL_BIT                 = 8;
    localparam int unsigned ISTEKCI_SAYISI_VARSAYILAN = 3;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

// File: rtl/idct_blok_hakemi_etiket_fifo.sv
// In-order tag FIFO: remembers which requester owns each block inside the transformer.
module etiket_fifo
    import idct_blok_hakemi_pkg::*;
#(
    parameter int unsigned GENISLIK = 2,
    parameter int unsigned DERINLIK = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [GENISLIK-1:0] veri,
    output logic [GENISLIK-1:0] bas,
    output logic                dolu,
    output logic                bos
);

    localparam int unsigned PTR_BIT  = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int unsigned SAYI_BIT = $clog2(DERINLIK + 1);

    logic [DERINLIK*GENISLIK-1:0] bellek;
    logic [PTR_BIT-1:0]           yaz_r;
    logic [PTR_BIT-1:0]           oku_r;
    logic [SAYI_BIT-1:0]          sayi_r;
    logic                         yaz_ok;
    logic                         oku_ok;

    function automatic logic [PTR_BIT-1:0] ilerlet(input logic [PTR_BIT-1:0] p);
        return (32'(p) == DERINLIK - 1) ? '0 : p + PTR_BIT'(1);
    endfunction

    assign bos    = (sayi_r == '0);
    assign dolu   = (sayi_r == SAYI_BIT'(DERINLIK));
    assign oku_ok = pop && !bos;
    // A pop in the same cycle frees the slot the push needs.
    assign yaz_ok = push && (!dolu || oku_ok);
    assign bas    = bellek[32'(oku_r)*GENISLIK +: GENISLIK];

    always_ff @(posedge clk) begin
        if (rst) begin
            bellek <= '0;
            yaz_r  <= '0;
            oku_r  <= '0;
            sayi_r <= '0;
        end else begin
            if (yaz_ok) begin
                bellek[32'(yaz_r)*GENISLIK +: GENISLIK] <= veri;
                yaz_r <= ilerlet(yaz_r);
            end
            if (oku_ok) begin
                oku_r <= ilerlet(oku_r);
            end
            case ({yaz_ok, oku_ok})
                2'b10:   sayi_r <= sayi_r + SAYI_BIT'(1);
                2'b01:   sayi_r <= sayi_r - SAYI_BIT'(1);
                default: sayi_r <= sayi_r;
            endcase
        end
    end

endmodule

// File: rtl/idct_blok_hakemi.sv
// Block-granular round-robin arbiter sharing one IDCT between dequantizer streams,
// tagging each transformer output block with the id of the requester that fed it.
module idct_blok_hakemi
    import idct_blok_hakemi_pkg::*;
#(
    parameter int unsigned ISTEKCI_SAYISI  = ISTEKCI_SAYISI_VARSAYILAN,
    parameter int unsigned ID_BIT          = 2,
    parameter int unsigned ETIKET_DERINLIK = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [ISTEKCI_SAYISI*Q_BIT-1:0]     ist_veri_i,
    input  logic [ISTEKCI_SAYISI*BLOCK_BIT-1:0] ist_row_i,
    input  logic [ISTEKCI_SAYISI*BLOCK_BIT-1:0] ist_col_i,
    input  logic [ISTEKCI_SAYISI-1:0]           ist_gecerli_i,
    input  logic [ISTEKCI_SAYISI-1:0]           ist_blok_son_i,
    output logic [ISTEKCI_SAYISI-1:0]           ist_hazir_o,
    output logic [Q_BIT-1:0]                    tr_veri_o,
    output logic [BLOCK_BIT-1:0]                tr_row_o,
    output logic [BLOCK_BIT-1:0]                tr_col_o,
    output logic                                tr_gecerli_o,
    output logic                                tr_blok_son_o,
    input  logic                                tr_hazir_i,
    input  logic [PIXEL_BIT-1:0]                tr_sonuc_veri_i,
    input  logic [BLOCK_BIT-1:0]                tr_sonuc_row_i,
    input  logic [BLOCK_BIT-1:0]                tr_sonuc_col_i,
    input  logic                                tr_sonuc_gecerli_i,
    input  logic                                tr_sonuc_blok_son_i,
    output logic                                tr_sonuc_hazir_o,
    output logic [PIXEL_BIT-1:0]                gd_veri_o,
    output logic [BLOCK_BIT-1:0]                gd_row_o,
    output logic [BLOCK_BIT-1:0]                gd_col_o,
    output logic [ID_BIT-1:0]                   gd_id_o,
    output logic                                gd_gecerli_o,
    output logic                                gd_blok_son_o,
    input  logic                                gd_hazir_i,
    output logic                                hata_o
);

    localparam int unsigned N       = ISTEKCI_SAYISI;
    localparam int unsigned SEC_BIT = $clog2(N);

    typedef enum logic {BOSTA, AKTAR} durum_t;

    durum_t              durum_r, durum_d;
    logic [ID_BIT-1:0]   kazanan_r, kazanan_d;
    logic [ID_BIT-1:0]   son_kazanan_r, son_kazanan_d;
    logic [SEC_BIT-1:0]  sec;
    logic                etiket_yaz;
    logic                etiket_oku;
    logic                dolu;
    logic                bos;
    logic                son_el;

    // First valid requester after the previous winner, wrapping modulo N.
    function automatic logic [ID_BIT-1:0] rr_sec(input logic [N-1:0] gecerli,
                                                  input logic [ID_BIT-1:0] son);
        logic [ID_BIT-1:0] secim;
        logic              bulundu;
        int unsigned       aday;
        secim   = son;
        bulundu = LOW;
        for (int unsigned i = 1; i <= N; i++) begin
            aday = (32'(son) + i) % N;
            if (!bulundu && gecerli[SEC_BIT'(aday)]) begin
                secim   = ID_BIT'(aday);
                bulundu = HIGH;
            end
        end
        return secim;
    endfunction

    assign sec       = SEC_BIT'(kazanan_r);
    assign tr_veri_o = ist_veri_i[32'(sec)*Q_BIT +: Q_BIT];
    assign tr_row_o  = ist_row_i[32'(sec)*BLOCK_BIT +: BLOCK_BIT];
    assign tr_col_o  = ist_col_i[32'(sec)*BLOCK_BIT +: BLOCK_BIT];
    assign son_el    = ist_gecerli_i[sec] && tr_hazir_i && ist_blok_son_i[sec];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_r       <= BOSTA;
            kazanan_r     <= '0;
            son_kazanan_r <= ID_BIT'(N - 1);
        end else begin
            durum_r       <= durum_d;
            kazanan_r     <= kazanan_d;
            son_kazanan_r <= son_kazanan_d;
        end
    end

    // Grant is held for the whole block; only the last-beat handshake releases it.
    always_comb begin
        durum_d       = durum_r;
        kazanan_d     = kazanan_r;
        son_kazanan_d = son_kazanan_r;
        ist_hazir_o   = '0;
        tr_gecerli_o  = LOW;
        tr_blok_son_o = LOW;
        etiket_yaz    = LOW;
        case (durum_r)
            BOSTA: begin
                if (|ist_gecerli_i && !dolu) begin
                    kazanan_d = rr_sec(ist_gecerli_i, son_kazanan_r);
                    durum_d   = AKTAR;
                end
            end
            AKTAR: begin
                ist_hazir_o[sec] = tr_hazir_i;
                tr_gecerli_o     = ist_gecerli_i[sec];
                tr_blok_son_o    = ist_blok_son_i[sec];
                if (son_el) begin
                    etiket_yaz    = HIGH;
                    son_kazanan_d = kazanan_r;
                    durum_d       = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    assign gd_gecerli_o     = tr_sonuc_gecerli_i && !bos;
    assign tr_sonuc_hazir_o = gd_hazir_i && !bos;
    assign gd_veri_o        = tr_sonuc_veri_i;
    assign gd_row_o         = tr_sonuc_row_i;
    assign gd_col_o         = tr_sonuc_col_i;
    assign gd_blok_son_o    = tr_sonuc_blok_son_i;
    assign etiket_oku       = tr_sonuc_gecerli_i && tr_sonuc_hazir_o && tr_sonuc_blok_son_i;

    etiket_fifo #(
        .GENISLIK (ID_BIT),
        .DERINLIK (ETIKET_DERINLIK)
    ) u_etiket_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (etiket_yaz),
        .pop  (etiket_oku),
        .veri (kazanan_r),
        .bas  (gd_id_o),
        .dolu (dolu),
        .bos  (bos)
    );

    // Sticky: output beats with no owner, or a tag with nowhere to go.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hata_o <= LOW;
        end else if ((tr_sonuc_gecerli_i && bos) || (etiket_yaz && dolu)) begin
            hata_o <= HIGH;
        end
    end

endmodule

// File: tb/tb_idct_blok_hakemi.sv
// Directed bench for idct_blok_hakemi; the bench itself plays the transformer.
module tb_idct_blok_hakemi;
    import idct_blok_hakemi_pkg::*;

    localparam int unsigned N   = 3;
    localparam int unsigned IDB = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N*Q_BIT-1:0]       ist_veri;
    logic [N*BLOCK_BIT-1:0]   ist_row, ist_col;
    logic [N-1:0]             ist_gecerli, ist_blok_son, ist_hazir;
    logic [Q_BIT-1:0]         tr_veri;
    logic [BLOCK_BIT-1:0]     tr_row, tr_col;
    logic                     tr_gecerli, tr_blok_son, tr_hazir;
    logic [PIXEL_BIT-1:0]     so_veri;
    logic [BLOCK_BIT-1:0]     so_row, so_col;
    logic                     so_gecerli, so_blok_son, so_hazir;
    logic [PIXEL_BIT-1:0]     gd_veri;
    logic [BLOCK_BIT-1:0]     gd_row, gd_col;
    logic [IDB-1:0]           gd_id;
    logic                     gd_gecerli, gd_blok_son, gd_hazir;
    logic                     hata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idct_blok_hakemi #(
        .ISTEKCI_SAYISI  (N),
        .ID_BIT          (IDB),
        .ETIKET_DERINLIK (2)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ist_veri_i          (ist_veri),
        .ist_row_i           (ist_row),
        .ist_col_i           (ist_col),
        .ist_gecerli_i       (ist_gecerli),
        .ist_blok_son_i      (ist_blok_son),
        .ist_hazir_o         (ist_hazir),
        .tr_veri_o           (tr_veri),
        .tr_row_o            (tr_row),
        .tr_col_o            (tr_col),
        .tr_gecerli_o        (tr_gecerli),
        .tr_blok_son_o       (tr_blok_son),
        .tr_hazir_i          (tr_hazir),
        .tr_sonuc_veri_i     (so_veri),
        .tr_sonuc_row_i      (so_row),
        .tr_sonuc_col_i      (so_col),
        .tr_sonuc_gecerli_i  (so_gecerli),
        .tr_sonuc_blok_son_i (so_blok_son),
        .tr_sonuc_hazir_o    (so_hazir),
        .gd_veri_o           (gd_veri),
        .gd_row_o            (gd_row),
        .gd_col_o            (gd_col),
        .gd_id_o             (gd_id),
        .gd_gecerli_o        (gd_gecerli),
        .gd_blok_son_o       (gd_blok_son),
        .gd_hazir_i          (gd_hazir),
        .hata_o              (hata)
    );

    function automatic logic [Q_BIT-1:0] katsayi(input int k, input int b);
        return Q_BIT'(k * 256 + b);
    endfunction

    function automatic logic [PIXEL_BIT-1:0] piksel(input int b);
        return PIXEL_BIT'(b * 3 + 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic ist_sur(input int k, input int b, input logic son, input logic v);
        ist_veri[k*Q_BIT +: Q_BIT]         = katsayi(k, b);
        ist_row[k*BLOCK_BIT +: BLOCK_BIT]  = BLOCK_BIT'(b / 8);
        ist_col[k*BLOCK_BIT +: BLOCK_BIT]  = BLOCK_BIT'(b % 8);
        ist_blok_son[k]                    = son;
        ist_gecerli[k]                     = v;
    endtask

    task automatic sonuc_sur(input int b, input logic son, input logic v);
        so_veri     = piksel(b);
        so_row      = BLOCK_BIT'(b / 8);
        so_col      = BLOCK_BIT'(b % 8);
        so_blok_son = son;
        so_gecerli  = v;
    endtask

    initial begin
        rst = 1'b1; tr_hazir = 1'b1; gd_hazir = 1'b1;
        ist_veri = '0; ist_row = '0; ist_col = '0; ist_gecerli = '0; ist_blok_son = '0;
        sonuc_sur(0, 1'b0, 1'b0);
        tick(); tick();
        settle();
        chk("rst_ist_hazir", 32'(ist_hazir), 32'(0));
        chk("rst_tr_gecerli", 32'(tr_gecerli), 32'(0));
        chk("rst_gd_gecerli", 32'(gd_gecerli), 32'(0));
        chk("rst_tr_sonuc_hazir", 32'(so_hazir), 32'(0));
        chk("rst_hata", 32'(hata), 32'(0));
        tick();
        rst = 1'b0; gd_hazir = 1'b0;

        // Single requester 1, 64-beat block
        ist_sur(1, 0, 1'b0, 1'b1);
        settle();
        chk("t1_bosta_hazir", 32'(ist_hazir), 32'(0));
        tick();
        for (int b = 0; b < 64; b++) begin
            ist_sur(1, b, 1'(b == 63), 1'b1);
            settle();
            chk("t1_hazir", 32'(ist_hazir), 32'(3'b010));
            chk("t1_tr_gecerli", 32'(tr_gecerli), 32'(1));
            chk("t1_tr_veri", 32'(tr_veri), 32'(katsayi(1, b)));
            chk("t1_tr_rowcol", 32'({tr_row, tr_col}), 32'(b));
            chk("t1_tr_blok_son", 32'(tr_blok_son), 32'(b == 63));
            tick();
        end
        ist_sur(1, 0, 1'b0, 1'b0);
        settle();
        chk("t1_after_hazir", 32'(ist_hazir), 32'(0));
        chk("t1_after_tr_gecerli", 32'(tr_gecerli), 32'(0));
        tick();
        gd_hazir = 1'b1;
        for (int b = 0; b < 64; b++) begin
            sonuc_sur(b, 1'(b == 63), 1'b1);
            settle();
            chk("t1_gd_gecerli", 32'(gd_gecerli), 32'(1));
            chk("t1_gd_id", 32'(gd_id), 32'(1));
            chk("t1_gd_veri", 32'(gd_veri), 32'(piksel(b)));
            chk("t1_gd_blok_son", 32'(gd_blok_son), 32'(b == 63));
            chk("t1_so_hazir", 32'(so_hazir), 32'(1));
            tick();
        end
        sonuc_sur(0, 1'b0, 1'b0);
        settle();
        chk("t1_hata", 32'(hata), 32'(0));
        tick();

        // All three requesters valid: grants 0,1,2,0,1,2; output of block g-1 overlaps input of block g
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int g = 0; g < 6; g++) begin
            for (int j = 0; j < 3; j++) ist_sur(j, 0, 1'b0, 1'b1);
            sonuc_sur(0, 1'b0, 1'b0);
            settle();
            chk("rr_idle_hazir", 32'(ist_hazir), 32'(0));
            chk("rr_idle_tr_gecerli", 32'(tr_gecerli), 32'(0));
            if (g > 0) chk("rr_idle_gd_id", 32'(gd_id), 32'((g - 1) % 3));
            tick();
            for (int b = 0; b < 64; b++) begin
                ist_sur(g % 3, b, 1'(b == 63), 1'b1);
                if (g > 0) sonuc_sur(b, 1'(b == 63), 1'b1);
                settle();
                chk("rr_grant", 32'(ist_hazir), 32'(1) << (g % 3));
                chk("rr_tr_veri", 32'(tr_veri), 32'(katsayi(g % 3, b)));
                if (g > 0) begin
                    chk("rr_gd_id", 32'(gd_id), 32'((g - 1) % 3));
                    chk("rr_gd_gecerli", 32'(gd_gecerli), 32'(1));
                end
                tick();
            end
        end
        for (int j = 0; j < 3; j++) ist_sur(j, 0, 1'b0, 1'b0);
        for (int b = 0; b < 64; b++) begin
            sonuc_sur(b, 1'(b == 63), 1'b1);
            settle();
            chk("rr_drain_gd_id", 32'(gd_id), 32'(2));
            chk("rr_drain_blok_son", 32'(gd_blok_son), 32'(b == 63));
            chk("rr_drain_hazir", 32'(ist_hazir), 32'(0));
            tick();
        end
        sonuc_sur(0, 1'b0, 1'b0);
        settle();
        chk("rr_hata", 32'(hata), 32'(0));
        chk("rr_empty_gd_gecerli", 32'(gd_gecerli), 32'(0));
        tick();

        // Tag FIFO full (depth 2, downstream stalled), requesters 0 and 1 with 2-beat blocks
        gd_hazir = 1'b0;
        ist_sur(0, 0, 1'b0, 1'b1);
        ist_sur(1, 0, 1'b0, 1'b1);
        settle();
        chk("full_f0", 32'(ist_hazir), 32'(0));
        tick();
        settle();
        chk("full_f1", 32'(ist_hazir), 32'(3'b001));
        tick();
        ist_sur(0, 1, 1'b1, 1'b1);
        settle();
        chk("full_f2", 32'(ist_hazir), 32'(3'b001));
        chk("full_f2_son", 32'(tr_blok_son), 32'(1));
        tick();
        ist_sur(0, 0, 1'b0, 1'b1);
        settle();
        chk("full_f3", 32'(ist_hazir), 32'(0));
        tick();
        settle();
        chk("full_f4", 32'(ist_hazir), 32'(3'b010));
        tick();
        ist_sur(1, 1, 1'b1, 1'b1);
        settle();
        chk("full_f5", 32'(ist_hazir), 32'(3'b010));
        tick();
        ist_sur(1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("full_no_grant", 32'(ist_hazir), 32'(0));
            chk("full_tr_gecerli", 32'(tr_gecerli), 32'(0));
            chk("full_head", 32'(gd_id), 32'(0));
            tick();
        end
        gd_hazir = 1'b1;
        sonuc_sur(0, 1'b1, 1'b1);
        settle();
        chk("full_pop_gd_gecerli", 32'(gd_gecerli), 32'(1));
        chk("full_pop_so_hazir", 32'(so_hazir), 32'(1));
        chk("full_pop_id", 32'(gd_id), 32'(0));
        chk("full_pop_hazir", 32'(ist_hazir), 32'(0));
        tick();
        sonuc_sur(0, 1'b0, 1'b0);
        settle();
        chk("full_after_pop_id", 32'(gd_id), 32'(1));
        chk("full_after_pop_hazir", 32'(ist_hazir), 32'(0));
        tick();
        settle();
        chk("full_regrant", 32'(ist_hazir), 32'(3'b001));
        tick();
        ist_sur(0, 1, 1'b1, 1'b1);
        settle();
        chk("full_regrant_son", 32'(ist_hazir), 32'(3'b001));
        tick();
        ist_sur(0, 0, 1'b0, 1'b0);
        ist_sur(1, 0, 1'b0, 1'b0);
        sonuc_sur(0, 1'b1, 1'b1);
        settle();
        chk("full_drain_id1", 32'(gd_id), 32'(1));
        tick();
        settle();
        chk("full_drain_id0", 32'(gd_id), 32'(0));
        chk("full_drain_gecerli", 32'(gd_gecerli), 32'(1));
        tick();
        sonuc_sur(0, 1'b0, 1'b0);
        settle();
        chk("full_hata", 32'(hata), 32'(0));
        tick();

        // Output beat with no tag: blocked and flagged until reset
        sonuc_sur(5, 1'b0, 1'b1);
        settle();
        chk("err_gd_gecerli", 32'(gd_gecerli), 32'(0));
        chk("err_so_hazir", 32'(so_hazir), 32'(0));
        chk("err_hata_same", 32'(hata), 32'(0));
        tick();
        sonuc_sur(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_hata_sticky", 32'(hata), 32'(1));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("err_hata_cleared", 32'(hata), 32'(0));
        tick();

        // Reset at beat 30 of requester 1's block, with tag 0 still queued
        gd_hazir = 1'b0;
        ist_sur(0, 0, 1'b0, 1'b1);
        settle();
        chk("mr_m0", 32'(ist_hazir), 32'(0));
        tick();
        settle();
        chk("mr_m1", 32'(ist_hazir), 32'(3'b001));
        tick();
        ist_sur(0, 1, 1'b1, 1'b1);
        settle();
        chk("mr_m2", 32'(ist_hazir), 32'(3'b001));
        tick();
        ist_sur(0, 0, 1'b0, 1'b0);
        ist_sur(1, 0, 1'b0, 1'b1);
        settle();
        chk("mr_m3", 32'(ist_hazir), 32'(0));
        tick();
        for (int b = 0; b < 30; b++) begin
            ist_sur(1, b, 1'b0, 1'b1);
            settle();
            chk("mr_beat", 32'(ist_hazir), 32'(3'b010));
            tick();
        end
        ist_sur(1, 30, 1'b0, 1'b1);
        rst = 1'b1;
        settle();
        chk("mr_beat30", 32'(ist_hazir), 32'(3'b010));
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) ist_sur(j, 0, 1'b0, 1'b1);
        gd_hazir = 1'b1;
        sonuc_sur(0, 1'b0, 1'b1);
        settle();
        chk("mr_hazir", 32'(ist_hazir), 32'(0));
        chk("mr_tr_gecerli", 32'(tr_gecerli), 32'(0));
        chk("mr_gd_gecerli", 32'(gd_gecerli), 32'(0));
        chk("mr_so_hazir", 32'(so_hazir), 32'(0));
        chk("mr_hata", 32'(hata), 32'(0));
        tick();
        sonuc_sur(0, 1'b0, 1'b0);
        settle();
        chk("mr_grant0", 32'(ist_hazir), 32'(3'b001));
        chk("mr_hata_empty", 32'(hata), 32'(1));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
